// File: rtl/keccak_squeeze_serializer.sv
// Keccak squeeze serializer: captures the rate part of a permuted state and streams it out lane by lane.
// Optional SQUEEZE_PRELOAD_EN lets a new state load on the final-lane handshake so blocks run back-to-back.
module keccak_squeeze_serializer #(
   parameter int N          = 1600,
   parameter int W          = 64,
   parameter int RATE_WORDS = 21
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         load,
   input  logic [N-1:0] state_in,
   output logic         load_ready,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic         out_last,
   output logic         block_done
);

   localparam int IDXW = (RATE_WORDS > 1) ? $clog2(RATE_WORDS) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(RATE_WORDS - 1);

   typedef enum logic {S_IDLE, S_STREAM} state_e;

   state_e                           state_q;
   logic [IDXW-1:0]                  idx_q;
   logic [RATE_WORDS-1:0][W-1:0]     buf_q;
   logic                             done_q;
   logic                             hs;
   logic                             take;

   // Capacity lanes are never stored.
   generate
      if (RATE_WORDS * W < N) begin : g_cap
         logic unused_cap;
         assign unused_cap = ^state_in[N-1:RATE_WORDS*W];
      end
   endgenerate

   assign out_valid  = (state_q == S_STREAM);
   assign out_last   = out_valid && (idx_q == LAST_IDX);
   assign out_data   = buf_q[idx_q];
   assign block_done = done_q;
   assign hs         = out_valid && out_ready;

`ifdef SQUEEZE_PRELOAD_EN
   assign load_ready = (state_q == S_IDLE) || (out_last && out_ready);
`else
   assign load_ready = (state_q == S_IDLE);
`endif

   assign take = load && load_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         buf_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (flush) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (take) begin
                     buf_q   <= state_in[RATE_WORDS*W-1:0];
                     idx_q   <= '0;
                     state_q <= S_STREAM;
                  end
               end
               S_STREAM: begin
                  if (hs) begin
                     if (out_last) begin
                        done_q <= 1'b1;
                        idx_q  <= '0;
                        // take can only be high here when preload is enabled
                        if (take) begin
                           buf_q   <= state_in[RATE_WORDS*W-1:0];
                           state_q <= S_STREAM;
                        end else begin
                           state_q <= S_IDLE;
                        end
                     end else begin
                        idx_q <= idx_q + IDXW'(1);
                     end
                  end
               end
               default: begin
                  state_q <= S_IDLE;
                  idx_q   <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_keccak_squeeze_serializer.sv
// Scoreboard bench: SHAKE128 (21 lanes) and SHAKE256 (17 lanes) instances; a negedge monitor pops expected lanes.
module tb_keccak_squeeze_serializer;

   localparam int N = 1600;
   localparam int W = 64;

   typedef struct {
      logic [W-1:0] d;
      logic         l;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         flush = 1'b0;
   logic         load = 1'b0;
   logic         load17 = 1'b0;
   logic         out_ready = 1'b1;
   logic [N-1:0] state_in = '0;

   logic         lr0, ov0, ol0, bd0;
   logic         lr1, ov1, ol1, bd1;
   logic [W-1:0] od0, od1;

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t q0[$];
   exp_t q1[$];
   bit           exp_done[2];
   bit           hold[2];
   logic [W-1:0] hold_od[2];
   logic         hold_ol[2];

   always #5 clk = ~clk;

   keccak_squeeze_serializer #(.N(N), .W(W), .RATE_WORDS(21)) u_dut (
      .clk(clk), .rst(rst), .flush(flush), .load(load), .state_in(state_in),
      .load_ready(lr0), .out_valid(ov0), .out_ready(out_ready),
      .out_data(od0), .out_last(ol0), .block_done(bd0)
   );

   keccak_squeeze_serializer #(.N(N), .W(W), .RATE_WORDS(17)) u_dut17 (
      .clk(clk), .rst(rst), .flush(flush), .load(load17), .state_in(state_in),
      .load_ready(lr1), .out_valid(ov1), .out_ready(out_ready),
      .out_data(od1), .out_last(ol1), .block_done(bd1)
   );

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [N-1:0] mk(input logic [W-1:0] base);
      logic [N-1:0] s;
      for (int i = 0; i < N / W; i++) s[W*i +: W] = base + W'(i);
      return s;
   endfunction

   task automatic mon(input int id, input logic v, input logic [W-1:0] d,
                      input logic l, input logic b);
      exp_t e;
      bit   hs;
      chk($sformatf("block_done%0d", id), {63'd0, b}, {63'd0, exp_done[id]});
      exp_done[id] = 1'b0;
      if (hold[id]) begin
         chk($sformatf("hold_valid%0d", id), {63'd0, v}, 64'd1);
         chk($sformatf("hold_data%0d", id), d, hold_od[id]);
         chk($sformatf("hold_last%0d", id), {63'd0, l}, {63'd0, hold_ol[id]});
      end
      hs = v && out_ready && !flush;
      if (hs) begin
         if ((id == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_lane%0d: got %h expected no lane", id, d);
         end else begin
            e = (id == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("lane_data%0d", id), d, e.d);
            chk($sformatf("lane_last%0d", id), {63'd0, l}, {63'd0, e.l});
            if (e.l) exp_done[id] = 1'b1;
         end
      end
      hold[id]    = v && !hs && !flush;
      hold_od[id] = d;
      hold_ol[id] = l;
   endtask

   always @(negedge clk) begin
      if (rst) begin
         mon(0, ov0, od0, ol0, bd0);
         mon(1, ov1, od1, ol1, bd1);
      end else begin
         for (int i = 0; i < 2; i++) begin
            exp_done[i] = 1'b0;
            hold[i]     = 1'b0;
         end
      end
   end

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic do_load(input int id, input logic [W-1:0] base);
      int rw;
      exp_t e;
      rw = (id == 0) ? 21 : 17;
      state_in = mk(base);
      if (id == 0) load = 1'b1; else load17 = 1'b1;
      for (int i = 0; i < rw; i++) begin
         e.d = base + W'(i);
         e.l = (i == rw - 1);
         if (id == 0) q0.push_back(e); else q1.push_back(e);
      end
      @(posedge clk); #1;
      load   = 1'b0;
      load17 = 1'b0;
   endtask

   task automatic wait_done(input int id, output int c);
      int k;
      for (k = 1; k <= 100; k++) begin
         @(negedge clk);
         if ((id == 0) ? bd0 : bd1) break;
      end
      c = k;
      @(posedge clk); #1;
   endtask

   initial begin
      int c;
      logic [3:0] pat;
      bit got;
      pat = 4'b1001;

      // Reset held three cycles with load asserted
      load = 1'b1;
      state_in = mk(64'h1111_2222_3333_4400);
      #2 rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("rst_valid", {63'd0, ov0}, 64'd0);
         chk("rst_done", {63'd0, bd0}, 64'd0);
         chk("rst_data", od0, 64'd0);
      end
      @(posedge clk); #1;
      rst  = 1'b1;
      load = 1'b0;
      @(negedge clk);
      chk("rst_load_ready", {63'd0, lr0}, 64'd1);
      chk("rst_valid_after", {63'd0, ov0}, 64'd0);
      @(posedge clk); #1;

      // SHAKE128 full block, out_ready held high
      out_ready = 1'b1;
      do_load(0, 64'h0101_0101_0101_0100);
      wait_done(0, c);
      chk("s128_done_latency", 64'(c), 64'd22);

      // Backpressure pattern 1,0,0,1
      do_load(0, 64'hA5A5_0000_0000_0000);
      got = 1'b0;
      for (int k = 0; k < 200; k++) begin
         out_ready = pat[k % 4];
         @(negedge clk);
         if (bd0) begin
            got = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      chk("bp_done_seen", {63'd0, got}, 64'd1);
      out_ready = 1'b1;
      @(posedge clk); #1;

      // Load while busy at lane 5 (SHAKE128)
      do_load(0, 64'hC000_0000_0000_0000);
      repeat (5) begin @(posedge clk); #1; end
      chk("busy_load_ready", {63'd0, lr0}, 64'd0);
      state_in = mk(64'hDEAD_0000_0000_0000);
      load = 1'b1;
      @(posedge clk); #1;
      load = 1'b0;
      wait_done(0, c);
      chk("busy_done_latency", 64'(c), 64'd16);

      // Load while busy at lane 5 (SHAKE256)
      do_load(1, 64'hE000_0000_0000_0000);
      repeat (5) begin @(posedge clk); #1; end
      chk("busy17_load_ready", {63'd0, lr1}, 64'd0);
      state_in = mk(64'hBEEF_0000_0000_0000);
      load17 = 1'b1;
      @(posedge clk); #1;
      load17 = 1'b0;
      wait_done(1, c);
      chk("s256_done_latency", 64'(c), 64'd12);

      // Flush together with load at lane 10
      do_load(0, 64'hF000_0000_0000_0000);
      repeat (10) begin @(posedge clk); #1; end
      chk("pre_flush_data", od0, 64'hF000_0000_0000_000A);
      flush = 1'b1;
      load  = 1'b1;
      state_in = mk(64'h6000_0000_0000_0000);
      @(posedge clk); #1;
      flush = 1'b0;
      load  = 1'b0;
      q0.delete();
      @(negedge clk);
      chk("flush_valid", {63'd0, ov0}, 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("flush_no_load", {63'd0, ov0}, 64'd0);
      @(posedge clk); #1;
      do_load(0, 64'h7000_0000_0000_0000);
      wait_done(0, c);
      chk("flush_restart_latency", 64'(c), 64'd22);

      // Load on the last-lane handshake
      do_load(0, 64'h8000_0000_0000_0000);
      repeat (20) begin @(posedge clk); #1; end
      chk("pl_at_last", {63'd0, ol0}, 64'd1);
      state_in = mk(64'h9000_0000_0000_0000);
      load = 1'b1;
`ifdef SQUEEZE_PRELOAD_EN
      for (int i = 0; i < 21; i++) begin
         exp_t e;
         e.d = 64'h9000_0000_0000_0000 + 64'(i);
         e.l = (i == 20);
         q0.push_back(e);
      end
      chk("pl_load_ready", {63'd0, lr0}, 64'd1);
      @(posedge clk); #1;
      load = 1'b0;
      @(negedge clk);
      chk("pl_valid", {63'd0, ov0}, 64'd1);
      chk("pl_lane0", od0, 64'h9000_0000_0000_0000);
      chk("pl_done", {63'd0, bd0}, 64'd1);
      @(posedge clk); #1;
      wait_done(0, c);
      chk("pl_second_latency", 64'(c), 64'd21);
`else
      chk("pl_load_ready", {63'd0, lr0}, 64'd0);
      @(posedge clk); #1;
      load = 1'b0;
      @(negedge clk);
      chk("pl_valid", {63'd0, ov0}, 64'd0);
      chk("pl_done", {63'd0, bd0}, 64'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("pl_ignored", {63'd0, ov0}, 64'd0);
      @(posedge clk); #1;
`endif

      repeat (3) @(posedge clk);
      #1;
      chk("q0_empty", 64'(q0.size()), 64'd0);
      chk("q1_empty", 64'(q1.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/keccak_squeeze_serializer.md
# keccak_squeeze_serializer

Unloads a 1600-bit Keccak state word by word, as the counterpart of the parallel state register. It captures the rate portion of the permuted state in one parallel load. It then streams that portion out as W-bit lanes over a valid/ready handshake, and pulses a block-done strobe so the controller can start the next permutation. It sits between the Keccak permutation core and the SHAKE consumers: the matrix expander, the sampler and the hash output.

## Interface
- `N`, 1600, width of the full Keccak state in bits.
- `W`, 64, output word (lane) width in bits; `N % W == 0`.
- `RATE_WORDS`, 21, lanes emitted per block (21 = SHAKE128, 17 = SHAKE256); `1 <= RATE_WORDS <= N/W`.
- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `flush` input 1: synchronous abort of the current block; returns the block to IDLE.
- `load` input 1: `state_in` is valid this cycle.
- `state_in` input N: permuted state; lane i is `state_in[W*i +: W]`.
- `load_ready` output 1: a load is accepted this cycle if `load` is high.
- `out_valid` output 1: `out_data` holds a valid lane.
- `out_ready` input 1: the consumer accepts the lane.
- `out_data` output W: current lane.
- `out_last` output 1: the current lane is lane `RATE_WORDS-1`.
- `block_done` output 1: one-cycle pulse after the last lane is accepted.

## Operation
- Storage is a `RATE_WORDS*W`-bit buffer. Lanes at index `>= RATE_WORDS` are never stored.
- Lane counter `idx` has width `clog2(RATE_WORDS)` (minimum 1). It counts 0..RATE_WORDS-1 and never wraps past RATE_WORDS-1.
- State IDLE:
  - `load_ready`=1, `out_valid`=0.
  - When `load` is high: capture `state_in[RATE_WORDS*W-1:0]`, set `idx`=0, go to STREAM.
- State STREAM:
  - `out_valid`=1, `out_data`=buffer lane `idx`, `out_last`=(`idx`==RATE_WORDS-1).
  - When `out_valid && out_ready` and not last: `idx` increments.
  - When `out_valid && out_ready` and last: `block_done` pulses on the next cycle and the block returns to IDLE (see Configuration).
  - Without handshake: `out_data` and `idx` hold stable. `out_valid` never drops while in STREAM.
- `load` while `load_ready`=0 is ignored; there is no buffering.
- `flush`:
  - From any state, the next state is IDLE, `idx`=0 and `out_valid`=0.
  - No `block_done` is produced.
  - `flush` takes priority over `load` and over the handshake in the same cycle.
- Reset values (async, while `rst`=0):
  - State IDLE, `idx`=0, buffer 0.
  - `out_valid`=0, `out_last`=0, `block_done`=0, `out_data`=0.
  - `load_ready`=1 after reset deassertion.
  - Reset asserted mid-block discards the block immediately.

## Timing
- Load-to-first-lane latency is 1 cycle: load accepted at edge k gives `out_valid`=1 with lane 0 at cycle k+1.
- Throughput is 1 lane per cycle when `out_ready` is held high. A full block takes RATE_WORDS cycles after the first valid cycle.
- `block_done` is registered: it is high exactly one cycle, the cycle after the last lane's handshake edge.
- All outputs are registered or decoded from registered state. There is no combinational path from `out_ready` or `load` to any output, except `load_ready` in the preload mode.

## Configuration
- `SQUEEZE_PRELOAD_EN` defined:
  - `load_ready` = IDLE, or (STREAM && `out_last` && `out_ready`).
  - A load in the same cycle as the last-lane handshake refills the buffer, sets `idx`=0 and stays in STREAM.
  - The block streams back-to-back with no bubble.
  - `block_done` still pulses for the finished block.
- Not defined:
  - `load_ready` = IDLE only.
  - There is at least one cycle with `out_valid`=0 between consecutive blocks.

## Test plan
- **Reset:** hold `rst`=0 for 3 cycles with `load`=1. Required: `out_valid`=0, `block_done`=0 and `out_data`=0 throughout; after release, `load_ready`=1.
- **SHAKE128 full block:** RATE_WORDS=21, `state_in` lane i = `64'h0101_0101_0101_0100 + i`, `out_ready`=1. Required:
  - 21 lanes in consecutive cycles, values i=0..20.
  - `out_last` high only on lane 20.
  - `block_done` one cycle after lane 20; lanes 21..24 never appear.
- **Backpressure:** toggle `out_ready` 1,0,0,1,… during a block. Required: `out_data` and `idx` are stable while `out_ready`=0, and no lane is skipped or duplicated.
- **Load while busy:** assert `load` with a new state at lane 5 of a block. Required: it is ignored and the original lanes 6..20 follow. With RATE_WORDS=17 (SHAKE256), the block ends after lane 16.
- **Flush:** assert `flush` together with `load` at lane 10. Required: the next cycle has `out_valid`=0, `load` is not accepted, no `block_done`, and a fresh load restarts at lane 0.
- **Preload:** with `SQUEEZE_PRELOAD_EN`, assert `load` on the last-lane handshake. Required:
  - The next cycle shows lane 0 of the new state with `out_valid` continuously 1.
  - `block_done`=1 in that same cycle.
  - Without the macro, the same stimulus is ignored and `out_valid`=0 for one cycle.
